coin_arb_vend_ctrl: RTL

COIN_ARB_VEND_CTRL -- requirements
Module: coin_arb_vend_ctrl

---
 rtl/coin_arb_vend_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/coin_arb_vend_ctrl.sv
// Vending controller: arbitrates coins from two inlets, accumulates credit, then drives vend and change handshakes.
// Latency: a coin credited at a clock edge shows on po_credit right after that edge; all outputs are registered.
// Backpressure: each inlet has a one-entry pending slot; a coin that finds the slot full and is not granted is dropped and po_reject pulses.
//
// Ports:
//   sys_clk, sys_rst_n              clock, synchronous active-low reset
//   pi_a_half/pi_a_one              inlet A coin pulses (both together = one "one" coin)
//   pi_b_half/pi_b_one              inlet B coin pulses
//   pi_vend_ack, pi_change_ack      dispenser / hopper completion pulses
//   pi_refund                       refund button (only when REFUND_BTN_EN is defined)
//   po_vend_req, po_change_req      level requests to dispenser / hopper
//   po_credit                       current credit in half-units
//   po_accept                       high while collecting coins
//   po_reject                       one-cycle pulse when a coin is discarded
// Optional feature macro: REFUND_BTN_EN (adds pi_refund and the refund path).
module coin_arb_vend_ctrl #(
  parameter int unsigned PRICE = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pi_a_half,
  input  logic       pi_a_one,
  input  logic       pi_b_half,
  input  logic       pi_b_one,
  input  logic       pi_vend_ack,
  input  logic       pi_change_ack,
`ifdef REFUND_BTN_EN
  input  logic       pi_refund,
`endif
  output logic       po_vend_req,
  output logic       po_change_req,
  output logic [3:0] po_credit,
  output logic       po_accept,
  output logic       po_reject
);

  localparam logic [3:0] PRICE_W = 4'(PRICE);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  state_t     state, state_nxt;
  logic [3:0] credit, credit_nxt;
  logic       pend_a_vld, pend_a_one, pend_a_vld_nxt, pend_a_one_nxt;
  logic       pend_b_vld, pend_b_one, pend_b_vld_nxt, pend_b_one_nxt;
  logic       last_b, last_b_nxt;  // 1: B was granted last, so A wins a tie
  logic       live_a, live_b, req_a, req_b, gnt_a, gnt_b;
  logic       rej_a, rej_b, coin_en, refund, refund_take, gnt_one;
  logic [3:0] gnt_val, credit_sum;

`ifdef REFUND_BTN_EN
  assign refund = pi_refund;
`else
  assign refund = 1'b0;
`endif

  // Arbitration and pending-slot bookkeeping
  always_comb begin
    live_a      = pi_a_half | pi_a_one;
    live_b      = pi_b_half | pi_b_one;
    refund_take = (state == COLLECT) && refund && (credit != 4'd0);
    // A refund cycle credits nothing; live coins still go to pending or reject.
    coin_en     = (state == COLLECT) && !refund_take;
    req_a       = coin_en && (pend_a_vld || live_a);
    req_b       = coin_en && (pend_b_vld || live_b);
    gnt_a       = req_a && (!req_b || last_b);
    gnt_b       = req_b && !gnt_a;
    // The pending entry is older than the live coin, so it is served first.
    gnt_one     = gnt_a ? (pend_a_vld ? pend_a_one : pi_a_one)
                        : (pend_b_vld ? pend_b_one : pi_b_one);
    gnt_val     = (gnt_a || gnt_b) ? (gnt_one ? 4'd2 : 4'd1) : 4'd0;

    pend_a_vld_nxt = pend_a_vld;
    pend_a_one_nxt = pend_a_one;
    rej_a          = 1'b0;
    if (gnt_a && pend_a_vld) begin
      // Slot drained this cycle; a live coin refills it.
      pend_a_vld_nxt = live_a;
      pend_a_one_nxt = pi_a_one;
    end else if (!gnt_a && live_a) begin
      if (pend_a_vld) begin
        rej_a = 1'b1;
      end else begin
        pend_a_vld_nxt = 1'b1;
        pend_a_one_nxt = pi_a_one;
      end
    end

    pend_b_vld_nxt = pend_b_vld;
    pend_b_one_nxt = pend_b_one;
    rej_b          = 1'b0;
    if (gnt_b && pend_b_vld) begin
      pend_b_vld_nxt = live_b;
      pend_b_one_nxt = pi_b_one;
    end else if (!gnt_b && live_b) begin
      if (pend_b_vld) begin
        rej_b = 1'b1;
      end else begin
        pend_b_vld_nxt = 1'b1;
        pend_b_one_nxt = pi_b_one;
      end
    end
  end

  // Next-state and credit
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    last_b_nxt = last_b;
    credit_sum = credit + gnt_val;
    if (gnt_a) begin
      last_b_nxt = 1'b0;
    end else if (gnt_b) begin
      last_b_nxt = 1'b1;
    end
    case (state)
      COLLECT: begin
        if (refund_take) begin
          state_nxt = CHANGE;
        end else begin
          credit_nxt = credit_sum;
          if (credit_sum >= PRICE_W) state_nxt = VEND;
        end
      end
      VEND: begin
        if (pi_vend_ack) begin
          credit_nxt = credit - PRICE_W;
          state_nxt  = (credit_nxt != 4'd0) ? CHANGE : COLLECT;
        end
      end
      CHANGE: begin
        if (credit == 4'd0) begin
          state_nxt = COLLECT;
        end else if (pi_change_ack) begin
          credit_nxt = credit - 4'd1;
          if (credit_nxt == 4'd0) state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state         <= COLLECT;
      credit        <= 4'd0;
      pend_a_vld    <= 1'b0;
      pend_a_one    <= 1'b0;
      pend_b_vld    <= 1'b0;
      pend_b_one    <= 1'b0;
      last_b        <= 1'b1;
      po_vend_req   <= 1'b0;
      po_change_req <= 1'b0;
      po_accept     <= 1'b1;
      po_reject     <= 1'b0;
    end else begin
      state         <= state_nxt;
      credit        <= credit_nxt;
      pend_a_vld    <= pend_a_vld_nxt;
      pend_a_one    <= pend_a_one_nxt;
      pend_b_vld    <= pend_b_vld_nxt;
      pend_b_one    <= pend_b_one_nxt;
      last_b        <= last_b_nxt;
      po_vend_req   <= (state_nxt == VEND);
      po_change_req <= (state_nxt == CHANGE);
      po_accept     <= (state_nxt == COLLECT);
      po_reject     <= rej_a | rej_b;
    end
  end

  assign po_credit = credit;

endmodule
